// File: rtl/four_input_nor_checker_if.sv
// ---------------------------------------------------------------------------
// four_input_nor_checker_if
//   Sample stream from the exercise harness into the response checker.
//   One beat carries the vector applied to the gate under test together with
//   the gate's output for that vector.
//
//   Handshake: sample_valid qualifies in_vec and dut_out for the current
//   cycle. There is no ready; the checker consumes every valid beat while it
//   is running and silently drops beats while idle or done. A beat presented
//   in the same cycle as a start pulse is also dropped.
//
//   Signals
//     sample_valid  1     beat present this cycle
//     in_vec        IN_W  vector applied to the gate, {a,b,c,d} with a = MSB
//     dut_out       1     gate output observed for in_vec
//
//   Modports
//     master  stimulus side (drives the beat)
//     slave   checker side (receives the beat)
// ---------------------------------------------------------------------------
interface four_input_nor_checker_if #(
  parameter int IN_W = 4
);
  logic            sample_valid;
  logic [IN_W-1:0] in_vec;
  logic            dut_out;

  modport master (
    output sample_valid,
    output in_vec,
    output dut_out
  );

  modport slave (
    input sample_valid,
    input in_vec,
    input dut_out
  );
endinterface

// File: rtl/four_input_nor_checker.sv
// ---------------------------------------------------------------------------
// four_input_nor_checker
//   Response checker for a combinational gate exercise. Each accepted beat is
//   graded against TRUTH_TABLE (bit i = expected output for vector i; the
//   default is a 4-input NOR). The block counts mismatches (saturating),
//   captures the first failing vector, and tracks which vectors were seen.
//   A run ends on full coverage or, if enabled, when the RUN-cycle budget
//   expires. done/pass let a bench or board LEDs grade the gate directly.
//
//   Ports
//     clk              in   rising-edge clock
//     rst_n            in   asynchronous active-low reset
//     start            in   begin/restart a run (single-cycle pulse)
//     smp              in   sample stream (slave modport): sample_valid,
//                           in_vec, dut_out
//     busy             out  1 while running
//     done             out  1 while holding results of a finished run
//     pass             out  done with zero mismatches and no timeout
//     timeout          out  run ended by the cycle budget, not by coverage
//     err_cnt          out  mismatch count, saturates at all-ones
//     first_err_valid  out  a mismatch has been captured this run
//     first_err_vec    out  in_vec of the first mismatch
//     cov_map          out  bit i set once vector i has been sampled
//     state_dbg        out  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
//   All outputs are registered; a beat's effect appears the cycle after the
//   edge that samples it.
// ---------------------------------------------------------------------------
module four_input_nor_checker #(
  parameter int                      IN_W        = 4,
  parameter logic [(1<<IN_W)-1:0]    TRUTH_TABLE = 16'h0001,
  parameter int                      ERR_CNT_W   = 8,
  parameter int                      TIMEOUT     = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  four_input_nor_checker_if.slave    smp,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       timeout,
  output logic [ERR_CNT_W-1:0]       err_cnt,
  output logic                       first_err_valid,
  output logic [IN_W-1:0]            first_err_vec,
  output logic [(1<<IN_W)-1:0]       cov_map,
  output logic [1:0]                 state_dbg
);

  localparam int NVEC  = 1 << IN_W;
  // Counter only needs to reach TIMEOUT-1; keep at least one bit so the
  // TIMEOUT=0 (disabled) configuration still elaborates cleanly.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [NVEC-1:0]  ONE_VEC = NVEC'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Cycle counter for the run budget (not an output).
  logic [CNT_W-1:0] cyc_cnt, cyc_cnt_next;

  // Next values of the registered results.
  logic                 busy_d;
  logic                 done_d;
  logic                 pass_d;
  logic                 timeout_d;
  logic [ERR_CNT_W-1:0] err_cnt_d;
  logic                 first_err_valid_d;
  logic [IN_W-1:0]      first_err_vec_d;
  logic [NVEC-1:0]      cov_map_d;

  // Beat decode.
  logic            accept;
  logic            exp_bit;
  logic            mismatch;
  logic [NVEC-1:0] onehot;
  logic            cov_full;
  logic            to_hit;

  always_comb begin
    accept   = (state == RUN) && smp.sample_valid && !start;
    exp_bit  = TRUTH_TABLE[smp.in_vec];
    onehot   = ONE_VEC << smp.in_vec;
    cov_full = &(cov_map | onehot);
    to_hit   = (TIMEOUT != 0) && (cyc_cnt == TO_LAST);
    // Written as an if so that an unknown dut_out falls through to the
    // mismatch default in simulation rather than being treated as a match.
    mismatch = 1'b1;
    if (smp.dut_out == exp_bit) mismatch = 1'b0;
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cyc_cnt <= '0;
    end else begin
      state   <= state_next;
      cyc_cnt <= cyc_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    cyc_cnt_next = cyc_cnt;
    unique case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        if (start) begin
          state_next = RUN;
        end else if (accept && cov_full) begin
          state_next = DONE;
        end else if (to_hit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase

    // Budget counts every RUN cycle and restarts on each entry to RUN.
    if (start) begin
      cyc_cnt_next = '0;
    end else if (state == RUN) begin
      cyc_cnt_next = cyc_cnt + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: output / result logic (next values, registered below)
  // -------------------------------------------------------------------------
  always_comb begin
    timeout_d         = timeout;
    err_cnt_d         = err_cnt;
    first_err_valid_d = first_err_valid;
    first_err_vec_d   = first_err_vec;
    cov_map_d         = cov_map;

    if (start) begin
      // Any start (including a restart mid-run) opens a fresh run.
      timeout_d         = 1'b0;
      err_cnt_d         = '0;
      first_err_valid_d = 1'b0;
      first_err_vec_d   = '0;
      cov_map_d         = '0;
    end else if (state == RUN) begin
      if (accept) begin
        cov_map_d = cov_map | onehot;
        if (mismatch) begin
          if (err_cnt != {ERR_CNT_W{1'b1}}) err_cnt_d = err_cnt + 1'b1;
          if (!first_err_valid) begin
            first_err_valid_d = 1'b1;
            first_err_vec_d   = smp.in_vec;
          end
        end
      end
      // Completion on the same cycle as budget expiry is a clean finish.
      if (to_hit && !(accept && cov_full)) timeout_d = 1'b1;
    end

    busy_d = (state_next == RUN);
    done_d = (state_next == DONE);
    pass_d = done_d && (err_cnt_d == '0) && !timeout_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      timeout         <= 1'b0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
      cov_map         <= '0;
      state_dbg       <= 2'd0;
    end else begin
      busy            <= busy_d;
      done            <= done_d;
      pass            <= pass_d;
      timeout         <= timeout_d;
      err_cnt         <= err_cnt_d;
      first_err_valid <= first_err_valid_d;
      first_err_vec   <= first_err_vec_d;
      cov_map         <= cov_map_d;
      state_dbg       <= state_next;
    end
  end

endmodule

// File: tb/tb_four_input_nor_checker.sv
// ---------------------------------------------------------------------------
// tb_four_input_nor_checker
//   Directed bench for four_input_nor_checker. Two instances share one
//   sample stream: dut_a uses the default parameters, dut_b narrows the
//   mismatch counter to 2 bits so saturation is reachable.
// ---------------------------------------------------------------------------
module tb_four_input_nor_checker;

  localparam int IN_W = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic start;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  four_input_nor_checker_if #(.IN_W(IN_W)) smp_bus ();

  // dut_a outputs
  logic        a_busy, a_done, a_pass, a_timeout, a_fev;
  logic [7:0]  a_err;
  logic [3:0]  a_fvec;
  logic [15:0] a_cov;
  logic [1:0]  a_state;
  // dut_b outputs
  logic        b_busy, b_done, b_pass, b_timeout, b_fev;
  logic [1:0]  b_err;
  logic [3:0]  b_fvec;
  logic [15:0] b_cov;
  logic [1:0]  b_state;

  four_input_nor_checker #(
    .IN_W(4), .TRUTH_TABLE(16'h0001), .ERR_CNT_W(8), .TIMEOUT(64)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .smp(smp_bus),
    .busy(a_busy), .done(a_done), .pass(a_pass), .timeout(a_timeout),
    .err_cnt(a_err), .first_err_valid(a_fev), .first_err_vec(a_fvec),
    .cov_map(a_cov), .state_dbg(a_state)
  );

  four_input_nor_checker #(
    .IN_W(4), .TRUTH_TABLE(16'h0001), .ERR_CNT_W(2), .TIMEOUT(64)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .smp(smp_bus),
    .busy(b_busy), .done(b_done), .pass(b_pass), .timeout(b_timeout),
    .err_cnt(b_err), .first_err_valid(b_fev), .first_err_vec(b_fvec),
    .cov_map(b_cov), .state_dbg(b_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; each call advances to the next
  // falling edge so outputs of the intervening rising edge can be checked.
  task automatic drive(input logic st, input logic vld, input logic [3:0] vec, input logic out);
    start                = st;
    smp_bus.sample_valid = vld;
    smp_bus.in_vec       = vec;
    smp_bus.dut_out      = out;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    drive(1'b1, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  // Reference gate: 4-input NOR of {a,b,c,d}.
  function automatic logic nor4(input logic [3:0] v);
    return ~(v[3] | v[2] | v[1] | v[0]);
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] exp_err;
    rst_n = 1'b0;
    start = 1'b0;
    smp_bus.sample_valid = 1'b0;
    smp_bus.in_vec       = 4'h0;
    smp_bus.dut_out      = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", {31'd0, a_busy}, 32'd0);
    check("rst_done", {31'd0, a_done}, 32'd0);
    check("rst_cov", {16'd0, a_cov}, 32'd0);
    check("rst_err", {24'd0, a_err}, 32'd0);
    rst_n = 1'b1;
    repeat (2) idle_cycle();
    check("idle_state", {30'd0, a_state}, 32'd0);

    // T1: clean run
    pulse_start();
    check("t1_busy", {31'd0, a_busy}, 32'd1);
    for (int v = 0; v < 16; v++) drive(1'b0, 1'b1, v[3:0], nor4(v[3:0]));
    check("t1_done", {31'd0, a_done}, 32'd1);
    check("t1_pass", {31'd0, a_pass}, 32'd1);
    check("t1_err", {24'd0, a_err}, 32'd0);
    check("t1_cov", {16'd0, a_cov}, 32'h0000FFFF);
    check("t1_busy_off", {31'd0, a_busy}, 32'd0);
    check("t1_timeout", {31'd0, a_timeout}, 32'd0);
    // DONE ignores beats and holds results.
    drive(1'b0, 1'b1, 4'h3, 1'b1);
    idle_cycle();
    check("t1_hold_err", {24'd0, a_err}, 32'd0);
    check("t1_hold_done", {31'd0, a_done}, 32'd1);

    // T2: errors at vectors 0 and 5; running count tracked per beat
    pulse_start();
    check("t2_clear_cov", {16'd0, a_cov}, 32'd0);
    exp_err = 8'd0;
    for (int v = 0; v < 16; v++) begin
      logic o;
      o = nor4(v[3:0]);
      if (v == 0) o = 1'b0;
      if (v == 5) o = 1'b1;
      if (o != ((v == 0) ? 1'b1 : 1'b0)) exp_err = exp_err + 8'd1;
      exp_q.push_back(exp_err);
      drive(1'b0, 1'b1, v[3:0], o);
      check($sformatf("t2_err_v%0d", v), {24'd0, a_err}, {24'd0, exp_q.pop_front()});
    end
    check("t2_err_final", {24'd0, a_err}, 32'd2);
    check("t2_fev", {31'd0, a_fev}, 32'd1);
    check("t2_fvec", {28'd0, a_fvec}, 32'd0);
    check("t2_pass", {31'd0, a_pass}, 32'd0);
    check("t2_done", {31'd0, a_done}, 32'd1);
    check("t2_b_err", {30'd0, b_err}, 32'd2);

    // T4: every output inverted; dut_b saturates at 3
    pulse_start();
    for (int v = 0; v < 16; v++) drive(1'b0, 1'b1, v[3:0], ~nor4(v[3:0]));
    check("t4_a_err", {24'd0, a_err}, 32'd16);
    check("t4_b_err", {30'd0, b_err}, 32'd3);
    check("t4_b_fvec", {28'd0, b_fvec}, 32'd0);
    check("t4_b_fev", {31'd0, b_fev}, 32'd1);
    check("t4_b_pass", {31'd0, b_pass}, 32'd0);
    check("t4_b_done", {31'd0, b_done}, 32'd1);

    // T3: vector 15 never sent; budget of 64 RUN cycles expires
    pulse_start();
    for (int k = 0; k < 63; k++) drive(1'b0, 1'b1, 4'(k % 15), nor4(4'(k % 15)));
    check("t3_busy_63", {31'd0, a_busy}, 32'd1);
    check("t3_done_63", {31'd0, a_done}, 32'd0);
    drive(1'b0, 1'b1, 4'(63 % 15), nor4(4'(63 % 15)));
    check("t3_done", {31'd0, a_done}, 32'd1);
    check("t3_timeout", {31'd0, a_timeout}, 32'd1);
    check("t3_cov", {16'd0, a_cov}, 32'h00007FFF);
    check("t3_pass", {31'd0, a_pass}, 32'd0);
    check("t3_err", {24'd0, a_err}, 32'd0);

    // T5: reset after 8 beats
    pulse_start();
    for (int v = 0; v < 8; v++) drive(1'b0, 1'b1, v[3:0], (v == 1) ? 1'b1 : nor4(v[3:0]));
    check("t5_cov_pre", {16'd0, a_cov}, 32'h000000FF);
    check("t5_err_pre", {24'd0, a_err}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", {31'd0, a_busy}, 32'd0);
    check("t5_rst_cov", {16'd0, a_cov}, 32'd0);
    check("t5_rst_err", {24'd0, a_err}, 32'd0);
    check("t5_rst_fev", {31'd0, a_fev}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int v = 8; v < 12; v++) drive(1'b0, 1'b1, v[3:0], 1'b1);
    check("t5_ignored_cov", {16'd0, a_cov}, 32'd0);
    check("t5_ignored_err", {24'd0, a_err}, 32'd0);
    check("t5_ignored_busy", {31'd0, a_busy}, 32'd0);

    // T6: start collides with a beat while running
    pulse_start();
    for (int v = 0; v < 3; v++) drive(1'b0, 1'b1, v[3:0], 1'b1);
    check("t6_cov_pre", {16'd0, a_cov}, 32'h00000007);
    drive(1'b1, 1'b1, 4'h3, 1'b1);
    check("t6_cov_clr", {16'd0, a_cov}, 32'd0);
    check("t6_err_clr", {24'd0, a_err}, 32'd0);
    check("t6_busy", {31'd0, a_busy}, 32'd1);
    check("t6_fev_clr", {31'd0, a_fev}, 32'd0);
    drive(1'b0, 1'b1, 4'h4, 1'b0);
    check("t6_cov_next", {16'd0, a_cov}, 32'h00000010);
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
